spatial_gradient_unit: RTL
==========================

Name: spatial_gradient_unit

Overview:
Downstream neighbour of the interpolation unit. Consumes the raster-ordered stream of interpolated window pixels, one (win_dim+1) x (win_dim+1) window at a time. For every interior window pixel it produces central-difference spatial gradients Ix and Iy. It buffers two previous rows in line buffers and a 3-column shift window, and feeds the downstream gradient-product/accumulation stage over a val/rdy handshake.

Parameters:
- pix_interp_width, 26, width of the unsigned interpolated pixel input.
- max_row_len, 32, line buffer depth; a row holds at most 32 pixels (win_dim <= 31).
- grad_width, pix_interp_width+1, width of the signed two's-complement gradient outputs.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- win_dim  in  5  last row/col index; a window is (win_dim+1)^2 pixels.
- in_msg  in  pix_interp_width  interpolated pixel, raster order (row-major).
- in_val  in  1  in_msg valid.
- in_rdy  out  1  block can accept in_msg this cycle.
- grad_x  out  grad_width  Ix = p[R][C+1] - p[R][C-1].
- grad_y  out  grad_width  Iy = p[R+1][C] - p[R-1][C].
- grad_last  out  1  marks the final interior output of a window, centre (win_dim-1, win_dim-1).
- out_val  out  1  grad_x/grad_y/grad_last valid.
- out_rdy  in  1  downstream accepts the output.

Behaviour:
- Reset: out_val=0, grad_x=0, grad_y=0, grad_last=0, row/col counters=0, shift window=0. Line buffer contents are don't-care and need no clear.
- A pixel is accepted when in_val && in_rdy. in_rdy = !out_val || out_rdy, a single output register with no skid buffer. in_rdy has no combinational path from in_val.
- Counters: col 0..win_dim, incremented on each accept. At win_dim, col wraps to 0 and row increments. At (win_dim, win_dim), both wrap to 0 and the next accepted pixel starts a new window with no bubble.
- Line buffers: lb_top holds row r-2 and lb_mid holds row r-1, each max_row_len entries, indexed by col, with combinational read. On accept at (r,c):
  - lb_top[c] <= lb_mid[c]; lb_mid[c] <= in_msg.
  - Shift window: top row shifts in lb_top[c], mid row shifts in lb_mid[c] (old values), bottom row shifts in in_msg. Each row is 3 columns: c, c-1, c-2.
- Gradient is computed when the accepted pixel is at (r,c) with r>=2 and c>=2; the centre is (R,C)=(r-1,c-1).
  - Ix = mid[c] - mid[c-2].
  - Iy = bot[c-1] - top[c-1].
  - Operands are zero-extended to grad_width before subtracting. The result is exact, with no halving or saturation; scaling by 1/2 is left downstream.
- Accepted pixels with r<2 or c<2 produce no output. Rows 0, 1 and columns 0, 1 of each row only fill buffers.
- Latency: 1 cycle. The output register loads on the accept edge, so out_val is high the cycle after the qualifying accept.
- out_val stays high, with grad_x, grad_y and grad_last held stable, until out_rdy. Accept and output-drain may occur in the same cycle (out_val && out_rdy && in_val).
- grad_last=1 iff the centre is (win_dim-1, win_dim-1). Output count per window is (win_dim-1)^2.
- win_dim < 2: pixels are accepted and counted, but no output is ever produced.
- win_dim must change only while both counters are 0; behaviour otherwise is undefined.
- Reset mid-window: the partial window is discarded, a pending output is dropped (out_val=0), and the next pixel is treated as (0,0).

Decomposition:
- Shared package: the PIX_INTERP_WIDTH and GRAD_WIDTH constants, and MAX_ROW_LEN, matching the interpolation unit's widths.
- One sub-module: spatial_gradient_line_buffer, parameterised depth and width, write-enable, combinational read at an index. Instantiate it twice.
- Counters, shift window, subtractors and output register stay in the top module.

Test Plan:
- win_dim=2, pixels 1..9, out_rdy=1 -> exactly one output: grad_x=6-4=2, grad_y=8-2=6, grad_last=1.
- win_dim=4, p[r][c]=10r+c -> 9 outputs, all grad_x=2, grad_y=20; grad_last only on the 9th; each output 1 cycle after the pixel at r>=2, c>=2.
- win_dim=2, pixels 9..1 (descending) -> grad_x=-2 (all ones except bit0 = 0, i.e. 0x7FFFFFE), grad_y=-6. Also all-ones max value minus 0 -> grad_x=+2^26-1, with no overflow.
- win_dim=4 ramp with out_rdy toggling 1,0,0,1 -> in_rdy=0 while out_val && !out_rdy; outputs held stable; same 9 values in order, none lost or duplicated.
- Two back-to-back win_dim=3 windows, second window = first + 100 -> 4 outputs each with identical gradients; grad_last on outputs 4 and 8; no bubble between windows.
- Reset asserted after 7 pixels of a win_dim=3 window, then a full fresh window -> out_val=0 the cycle after reset; fresh window yields exactly 4 correct outputs.

Source files
------------

// File: rtl/spatial_gradient_unit_pkg.sv
// Shared widths and types for the spatial gradient stage.
package spatial_gradient_unit_pkg;

    localparam int unsigned PIX_INTERP_WIDTH = 26;
    localparam int unsigned GRAD_WIDTH       = PIX_INTERP_WIDTH + 1;
    localparam int unsigned MAX_ROW_LEN      = 32;
    localparam int unsigned DIM_WIDTH        = 5;
    localparam int unsigned IDX_WIDTH        = $clog2(MAX_ROW_LEN);

    typedef logic        [PIX_INTERP_WIDTH-1:0] pix_t;
    typedef logic signed [GRAD_WIDTH-1:0]       grad_t;
    typedef logic        [DIM_WIDTH-1:0]        dim_t;

    typedef struct packed {
        grad_t grad_x;
        grad_t grad_y;
        logic  grad_last;
    } grad_out_t;

    // Exact difference of two unsigned pixels, zero-extended by one bit first.
    function automatic grad_t grad_diff(input pix_t a, input pix_t b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

endpackage

// File: rtl/spatial_gradient_unit_if.sv
// Pixel-in / gradient-out stream bundle for the spatial gradient stage.
interface spatial_gradient_unit_if;
    import spatial_gradient_unit_pkg::*;

    dim_t  win_dim;
    pix_t  in_msg;
    logic  in_val;
    logic  in_rdy;
    grad_t grad_x;
    grad_t grad_y;
    logic  grad_last;
    logic  out_val;
    logic  out_rdy;

    modport master (
        output win_dim, in_msg, in_val, out_rdy,
        input  in_rdy, grad_x, grad_y, grad_last, out_val
    );

    modport slave (
        input  win_dim, in_msg, in_val, out_rdy,
        output in_rdy, grad_x, grad_y, grad_last, out_val
    );

endinterface

// File: rtl/spatial_gradient_line_buffer.sv
// One-row line buffer: write-enabled store, combinational read at the same index.
module spatial_gradient_line_buffer #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 26
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage write; contents need no reset, every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/spatial_gradient_unit.sv
// Central-difference Ix/Iy over a raster window using two line buffers and a column window.
module spatial_gradient_unit
    import spatial_gradient_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    spatial_gradient_unit_if.slave  sg
);

    logic      w_in_rdy;
    logic      w_accept;
    logic      w_col_end;
    logic      w_row_end;
    logic      w_emit;
    pix_t      w_top_rd;
    pix_t      w_mid_rd;
    grad_out_t w_out_nxt;

    dim_t      r_row;
    dim_t      r_col;
    pix_t      r_top_c1;
    pix_t      r_mid_c1;
    pix_t      r_mid_c2;
    pix_t      r_bot_c1;
    grad_out_t r_out;
    logic      r_out_val;

    assign w_in_rdy  = !r_out_val || sg.out_rdy;
    assign w_accept  = sg.in_val && w_in_rdy;
    assign w_col_end = (r_col == sg.win_dim);
    assign w_row_end = (r_row == sg.win_dim);
    assign w_emit    = w_accept && (r_row >= DIM_WIDTH'(2)) && (r_col >= DIM_WIDTH'(2));

    spatial_gradient_line_buffer #(
        .DEPTH (MAX_ROW_LEN),
        .WIDTH (PIX_INTERP_WIDTH)
    ) u_lb_top (
        .clk     (clk),
        .i_we    (w_accept),
        .i_idx   (IDX_WIDTH'(r_col)),
        .i_wdata (w_mid_rd),
        .o_rdata (w_top_rd)
    );

    spatial_gradient_line_buffer #(
        .DEPTH (MAX_ROW_LEN),
        .WIDTH (PIX_INTERP_WIDTH)
    ) u_lb_mid (
        .clk     (clk),
        .i_we    (w_accept),
        .i_idx   (IDX_WIDTH'(r_col)),
        .i_wdata (sg.in_msg),
        .o_rdata (w_mid_rd)
    );

    // Row/column position of the next accepted pixel; wraps at win_dim with no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + DIM_WIDTH'(1);
            end else begin
                r_col <= r_col + DIM_WIDTH'(1);
            end
        end
    end

    // Column history; the current column is the live line-buffer read / in_msg.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_top_c1 <= '0;
            r_mid_c1 <= '0;
            r_mid_c2 <= '0;
            r_bot_c1 <= '0;
        end else if (w_accept) begin
            r_top_c1 <= w_top_rd;
            r_mid_c2 <= r_mid_c1;
            r_mid_c1 <= w_mid_rd;
            r_bot_c1 <= sg.in_msg;
        end
    end

    // Gradients centred one row up and one column left of the incoming pixel.
    always_comb begin
        w_out_nxt           = '0;
        w_out_nxt.grad_x    = grad_diff(w_mid_rd, r_mid_c2);
        w_out_nxt.grad_y    = grad_diff(r_bot_c1, r_top_c1);
        w_out_nxt.grad_last = w_row_end && w_col_end;
    end

    // Single output register: load on a qualifying accept, clear valid on drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= '0;
            r_out_val <= 1'b0;
        end else if (w_emit) begin
            r_out     <= w_out_nxt;
            r_out_val <= 1'b1;
        end else if (sg.out_rdy) begin
            r_out_val <= 1'b0;
        end
    end

    assign sg.in_rdy    = w_in_rdy;
    assign sg.out_val   = r_out_val;
    assign sg.grad_x    = r_out.grad_x;
    assign sg.grad_y    = r_out.grad_y;
    assign sg.grad_last = r_out.grad_last;

endmodule
